vga_pixel_scheduler: RTL and testbench
======================================

// Module: vga_pixel_scheduler
// PURPOSE
// - Sequences the VGA pixel path from the single INTERNAL_OSC domain. No derived clock is generated.
// - Programmable divider makes a one-cycle pixel clock-enable (pix_ce). H/V counters advance on pix_ce and produce sync/blank timing.
// - The divide ratio is reconfigured through a valid/ready port. A new ratio takes effect only at a frame boundary, so no frame is ever torn.
// PARAMETERS
// H_ACTIVE 640 visible pixels/line;  H_FP 16;  H_SYNC 96;  H_BP 48  (H_TOTAL = 800)
// V_ACTIVE 480 visible lines;  V_FP 10;  V_SYNC 2;  V_BP 33  (V_TOTAL = 525)
// DIV_W 4 width of divide ratio;  DIV_DEFAULT 2 ratio after reset
// HSYNC_POL 0 (0 = active-low);  VSYNC_POL 0 (0 = active-low)
// PORTS
// INTERNAL_OSC  in   1      sole clock, all logic posedge
// RESET         in   1      synchronous, active-high
// enable        in   1      1 = run timing, 0 = stop after current frame
// cfg_div       in   DIV_W  requested divide ratio (INTERNAL_OSC cycles per pixel)
// cfg_valid     in   1      cfg_div offered
// cfg_ready     out  1      1 = no ratio pending; transfer when cfg_valid&cfg_ready
// pix_ce        out  1      one-cycle pixel enable
// hsync, vsync  out  1      sync, polarity per *_POL
// active        out  1      1 inside H_ACTIVE x V_ACTIVE
// x, y          out  10     current h / v count
// line_start    out  1      pulse: pix_ce cycle where h==0
// frame_start   out  1      pulse: pix_ce cycle where h==0 && v==0
// running       out  1      1 in RUN or DRAIN
// BEHAVIOUR
// - Reset values:
//   - state = IDLE; div_cur = DIV_DEFAULT; no ratio pending; div counter = 0; h = v = 0.
//   - pix_ce, active, line_start, frame_start, running = 0; x = y = 0.
//   - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL (inactive levels); cfg_ready = 1.
// - Effective ratio: div_eff = (div_cur < 2) ? 1 : div_cur.
//   - The div counter counts 0..div_eff-1 while in RUN/DRAIN.
//   - pix_ce = 1 on the cycle in which the counter == div_eff-1. With div_eff = 1, pix_ce is high every cycle.
// - Counters: on pix_ce, h increments and wraps at H_TOTAL-1 -> 0. When h wraps, v increments and wraps at V_TOTAL-1 -> 0.
// - Outputs are combinational decodes of the registered h/v. They are therefore consistent with x/y in the same cycle.
//   - active: h < H_ACTIVE && v < V_ACTIVE.
//   - hsync asserted: H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC.
//   - vsync asserted: V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC.
//   - line_start, frame_start: pix_ce gated by (h,v) equal to (0,*) and (0,0) respectively.
// - FSM:
//   - IDLE: counters held at 0, all pulses 0. enable = 1 -> RUN next cycle; the div counter starts at 0.
//   - RUN: free-running frames. enable = 0 -> DRAIN.
//   - DRAIN: finishes the current frame.
//     - enable re-asserted -> RUN; the frame continues seamlessly.
//     - pix_ce at (H_TOTAL-1, V_TOTAL-1) -> IDLE; h, v and the div counter return to 0.
// - Config handshake:
//   - A transfer latches cfg_div into div_pend; cfg_ready = 0 next cycle.
//   - div_pend loads into div_cur on the pix_ce at (H_TOTAL-1, V_TOTAL-1). The div counter clears that cycle and cfg_ready = 1 next cycle.
//   - In IDLE, a pending ratio applies on the next cycle.
//   - A transfer in the same cycle as a boundary is applied at the following boundary, not the current one.
//   - cfg_valid while cfg_ready = 0 is ignored; the master holds it.
// - RESET mid-frame: all state returns to reset values on the next edge. The pending ratio is discarded.
// - All counters are unsigned with no overflow beyond the defined wraps.
// TESTING
// - Reset: hold RESET 3 cycles, enable = 0 -> pix_ce = 0, hsync = vsync = 1, x = y = 0, cfg_ready = 1, running = 0.
// - Default timing: enable = 1, div = 2 -> pix_ce every 2nd cycle; hsync low 192 clocks per 1600-clock line; vsync low 2 lines; frame = 840000 clocks.
// - Config mid-frame: cfg_div = 4 accepted at v = 100 -> cfg_ready = 0, pix_ce spacing stays 2 to frame end, then 4; cfg_ready = 1 after the boundary.
// - Degenerate ratio: cfg_div = 0 then 1 -> pix_ce high every cycle; frame = 420000 clocks.
// - Enable drop: enable = 0 at v = 300 -> frame completes to (799,524), then running = 0 and counters at 0; re-enable -> frame_start after 1 pixel period.
// - Reset mid-frame with cfg pending: RESET at v = 200 -> reset values, div_cur = 2, cfg_ready = 1, pending ratio lost.

Source files
------------

// File: rtl/vga_pixel_scheduler.sv
// VGA pixel-path sequencer: divided pixel clock-enable, H/V timing counters and
// a frame-boundary-synchronised divide-ratio reconfiguration port.
module vga_pixel_scheduler #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned DIV_W       = 4,
  parameter int unsigned DIV_DEFAULT = 2,
  parameter int unsigned HSYNC_POL   = 0,
  parameter int unsigned VSYNC_POL   = 0
) (
  input  logic             INTERNAL_OSC,
  input  logic             RESET,
  input  logic             enable,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic             pix_ce,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic [9:0]       x,
  output logic [9:0]       y,
  output logic             line_start,
  output logic             frame_start,
  output logic             running
);

  localparam int unsigned CW      = 10;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DIV_W-1:0] div_cur;
  logic [DIV_W-1:0] div_pend;
  logic             pend_valid;
  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_eff;
  logic [CW-1:0]    h;
  logic [CW-1:0]    v;
  logic             h_last;
  logic             v_last;
  logic             frame_end;
  logic             hs_on;
  logic             vs_on;

  // Ratios 0 and 1 both mean one pixel per oscillator cycle
  assign div_eff   = (div_cur < DIV_W'(2)) ? DIV_W'(1) : div_cur;
  assign running   = (state != IDLE);
  assign pix_ce    = running && (div_cnt == div_eff - DIV_W'(1));
  assign h_last    = (h == CW'(H_TOTAL - 1));
  assign v_last    = (v == CW'(V_TOTAL - 1));
  assign frame_end = pix_ce && h_last && v_last;

  assign hs_on = (h >= CW'(H_ACTIVE + H_FP)) && (h < CW'(H_ACTIVE + H_FP + H_SYNC));
  assign vs_on = (v >= CW'(V_ACTIVE + V_FP)) && (v < CW'(V_ACTIVE + V_FP + V_SYNC));

  assign hsync       = hs_on ? 1'(HSYNC_POL) : ~1'(HSYNC_POL);
  assign vsync       = vs_on ? 1'(VSYNC_POL) : ~1'(VSYNC_POL);
  assign active      = running && (h < CW'(H_ACTIVE)) && (v < CW'(V_ACTIVE));
  assign line_start  = pix_ce && (h == '0);
  assign frame_start = pix_ce && (h == '0) && (v == '0);
  assign x           = h;
  assign y           = v;
  assign cfg_ready   = ~pend_valid;

  always_ff @(posedge INTERNAL_OSC) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (!enable) state_next = DRAIN;
      DRAIN: begin
        if (enable)         state_next = RUN;
        else if (frame_end) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Divider, raster counters and the pending-ratio register
  always_ff @(posedge INTERNAL_OSC) begin
    if (RESET) begin
      div_cur    <= DIV_W'(DIV_DEFAULT);
      div_pend   <= '0;
      pend_valid <= 1'b0;
      div_cnt    <= '0;
      h          <= '0;
      v          <= '0;
    end else begin
      if (state == IDLE) begin
        div_cnt <= '0;
        h       <= '0;
        v       <= '0;
        if (pend_valid) begin
          div_cur    <= div_pend;
          pend_valid <= 1'b0;
        end
      end else begin
        if (pix_ce) begin
          div_cnt <= '0;
          if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + CW'(1);
          end else begin
            h <= h + CW'(1);
          end
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
        // New ratio only at the frame boundary, where the divider restarts anyway
        if (frame_end && pend_valid) begin
          div_cur    <= div_pend;
          pend_valid <= 1'b0;
        end
      end
      if (cfg_valid && !pend_valid) begin
        div_pend   <= cfg_div;
        pend_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_pixel_scheduler.sv
// Bench for vga_pixel_scheduler on a shrunken raster: directed scenarios plus
// random stimulus, every cycle compared against a linear-position frame model.
module tb_vga_pixel_scheduler;

  localparam int HA = 8, HFP = 2, HS = 3, HBP = 2;
  localparam int VA = 6, VFP = 1, VS = 2, VBP = 2;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FRAME = HT * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [3:0] cd = '0;
  logic       cv = 1'b0;
  logic       cfg_ready, pix_ce, hsync, vsync, active, line_start, frame_start, running;
  logic [9:0] x, y;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fs_q[$];

  // Model: frame position as one linear pixel index, phase within the pixel
  int m_mode = 0;   // 0 stopped, 1 free-running, 2 finishing the frame
  int m_phase = 0;
  int m_pos = 0;
  int m_ratio = 2;
  int m_pend[$];

  vga_pixel_scheduler #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
    .DIV_W(4), .DIV_DEFAULT(2), .HSYNC_POL(0), .VSYNC_POL(0)
  ) dut (
    .INTERNAL_OSC(clk), .RESET(rst), .enable(en), .cfg_div(cd), .cfg_valid(cv),
    .cfg_ready(cfg_ready), .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync),
    .active(active), .x(x), .y(y), .line_start(line_start),
    .frame_start(frame_start), .running(running)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got 'h%0h expected 'h%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int eff_ratio();
    return (m_ratio < 2) ? 1 : m_ratio;
  endfunction

  function automatic logic [27:0] model_out();
    int  h = m_pos % HT;
    int  v = m_pos / HT;
    bit  on = (m_mode != 0);
    bit  ce = on && (m_phase == eff_ratio() - 1);
    bit  hs = (h >= HA + HFP) && (h < HA + HFP + HS);
    bit  vs = (v >= VA + VFP) && (v < VA + VFP + VS);
    logic [9:0] hx = 10'(h);
    logic [9:0] vy = 10'(v);
    return {hx, vy, ce, ~hs, ~vs, on && h < HA && v < VA,
            ce && h == 0, ce && m_pos == 0, on, m_pend.size() == 0};
  endfunction

  task automatic model_update();
    bit ce, bnd, acc;
    if (rst) begin
      m_mode = 0; m_phase = 0; m_pos = 0; m_ratio = 2;
      m_pend.delete();
      return;
    end
    ce  = (m_mode != 0) && (m_phase == eff_ratio() - 1);
    bnd = ce && (m_pos == FRAME - 1);
    acc = cv && (m_pend.size() == 0);
    if (m_mode == 0) begin
      if (m_pend.size() != 0) m_ratio = m_pend.pop_front();
      if (en) m_mode = 1;
    end else begin
      if (ce) begin
        m_phase = 0;
        m_pos = (m_pos + 1) % FRAME;
      end else begin
        m_phase++;
      end
      if (bnd && m_pend.size() != 0) m_ratio = m_pend.pop_front();
      if (m_mode == 1 && !en) m_mode = 2;
      else if (m_mode == 2) m_mode = en ? 1 : (bnd ? 0 : 2);
    end
    if (acc) m_pend.push_back(int'(cd));
  endtask

  // One clock: drive, let the edge happen, then compare at the falling edge
  task automatic step(input logic r, input logic e, input logic v_in, input logic [3:0] d);
    rst = r; en = e; cv = v_in; cd = d;
    @(posedge clk);
    model_update();
    @(negedge clk);
    cyc++;
    chk("outputs", {x, y, pix_ce, hsync, vsync, active, line_start, frame_start,
                    running, cfg_ready}, model_out());
    if (frame_start) fs_q.push_back(cyc);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 4'd0);
  endtask

  task automatic check_gap(input string tag, input int exp);
    if (fs_q.size() < 2) chk(tag, 32'(fs_q.size()), 32'(exp));
    else chk(tag, 32'(fs_q[$] - fs_q[$-1]), 32'(exp));
  endtask

  initial begin
    int n;
    bit rnd_en;
    @(negedge clk);

    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("rst_pix_ce", 32'(pix_ce), 32'd0);
    chk("rst_sync", 32'({hsync, vsync}), 32'b11);
    chk("rst_xy", 32'({x, y}), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_active", 32'(active), 32'd0);

    // Default ratio 2
    fs_q.delete();
    run(3 * FRAME * 2 + 10);
    check_gap("frame_len_div2", FRAME * 2);

    // Ratio 4 offered mid-frame; old ratio holds until the boundary
    run(FRAME);
    step(1'b0, 1'b1, 1'b1, 4'd4);
    chk("cfg_busy", 32'(cfg_ready), 32'd0);
    fs_q.delete();
    run(FRAME * 2 + FRAME * 4 * 2 + 10);
    check_gap("frame_len_div4", FRAME * 4);
    chk("cfg_ready_after", 32'(cfg_ready), 32'd1);

    // Degenerate ratios 0 and 1
    step(1'b0, 1'b1, 1'b1, 4'd0);
    fs_q.delete();
    run(FRAME * 4 + FRAME * 2 + 10);
    check_gap("frame_len_div0", FRAME);
    step(1'b0, 1'b1, 1'b1, 4'd1);
    fs_q.delete();
    run(FRAME * 3 + 10);
    check_gap("frame_len_div1", FRAME);

    // Enable drop: frame completes, then idle at origin
    n = 0;
    step(1'b0, 1'b0, 1'b0, 4'd0);
    while (running && n < 4 * FRAME) begin
      step(1'b0, 1'b0, 1'b0, 4'd0);
      n++;
    end
    chk("drain_stopped", 32'(running), 32'd0);
    chk("drain_xy", 32'({x, y}), 32'd0);
    n = 0;
    fs_q.delete();
    while (fs_q.size() == 0 && n < 50) begin
      step(1'b0, 1'b1, 1'b0, 4'd0);
      n++;
    end
    chk("reenable_latency", 32'(n), 32'd1);

    // Reset with a ratio pending discards it
    run(FRAME / 2);
    step(1'b0, 1'b1, 1'b1, 4'd7);
    chk("pend_busy", 32'(cfg_ready), 32'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    chk("rst_mid_ready", 32'(cfg_ready), 32'd1);
    chk("rst_mid_xy", 32'({x, y, running}), 32'd0);
    fs_q.delete();
    run(3 * FRAME * 2 + 10);
    check_gap("rst_mid_div2", FRAME * 2);

    // Random traffic
    rnd_en = 1'b1;
    for (int i = 0; i < 30000; i++) begin
      if ($urandom % 400 == 0) rnd_en = ~rnd_en;
      step(($urandom % 5000) == 0, rnd_en, ($urandom % 25) == 0, 4'($urandom % 16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
